multicycle_main_control: RTL
============================

# multicycle_main_control

Multicycle main control unit for the RV32I-subset datapath. It is a Moore-style FSM with memory-ready handshake gating. It decodes the opcode field of the instruction register and sequences fetch, decode, execute, memory and writeback. It is the producer of the 2-bit ALUOp that the ALU control decoder consumes together with funct7/funct3. It also drives every datapath enable and mux select.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- instruction  in  32  instruction register contents; only [6:0] opcode is used
- mem_ready  in  1  memory completes the current read/write this cycle
- alu_op  out  2  00 add, 01 subtract, 10 decode funct fields
- alu_src_a  out  1  0 = PC, 1 = rs1 register
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- reg_write  out  1  register file write
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register to rd
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state encoding, for debug

## Operation
- Supported opcodes: R-type 0110011, LW 0000011, SW 0100011, BEQ 1100011. Any other opcode is illegal.
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4
  - MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8
- Encodings 9–15 are unreachable. If entered, they behave as FETCH on the next edge with all outputs 0.
- Outputs are decoded from state. Any signal not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_write and pc_write equal mem_ready, the only Mealy terms.
  - Stay in FETCH while mem_ready=0; on mem_ready=1 go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute).
  - Next state: LW/SW → MEM_ADDR, R-type → EXECUTE, BEQ → BRANCH.
  - Illegal opcode: illegal=1 this cycle, then FETCH.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: LW → MEM_READ, SW → MEM_WRITE. The opcode is re-sampled from instruction, which is stable.
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10, then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, then FETCH.
- Only one of mem_read and mem_write is ever asserted at a time. reg_write is never asserted in the same cycle as mem_write.

## Timing
- rst_n low at a rising edge puts state in FETCH.
- While rst_n is low, every output is forced to 0, including alu_op=00 and illegal=0. This holds regardless of state, so no memory strobe is issued during reset.
- Reset asserted mid-instruction aborts the instruction. No further writes occur, and the first cycle after release is FETCH.
- Cycles per instruction with zero memory wait:
  - BEQ 3, R-type 4, SW 4, LW 5.
  - Each memory wait cycle adds 1 in FETCH, MEM_READ or MEM_WRITE.
- illegal is high for exactly the DECODE cycle; the next cycle is FETCH.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- An instruction change outside FETCH is ignored except where the opcode is sampled: DECODE and MEM_ADDR.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles with mem_ready=1.
  - Response: all outputs 0 throughout. After release, state=0, mem_read=1, alu_src_b=01.
- R-type add:
  - Stimulus: instruction=0x002081B3, mem_ready=1.
  - Response: states 0,1,6,7,0; alu_op=10 in state 6; reg_write=1 only in state 7.
- LW with wait:
  - Stimulus: instruction=0x0000A183; mem_ready low for 2 cycles in MEM_READ.
  - Response: states 0,1,2,3,3,3,4,0; mem_read=1 and iord=1 in all three state-3 cycles.
- SW and BEQ:
  - SW 0x0030A023 → states 0,1,2,5,0 with mem_write=1 for one cycle.
  - BEQ 0x00208463 → states 0,1,8,0 with alu_op=01 and pc_write_cond=1 in state 8.
- Illegal opcode:
  - Stimulus: instruction=0x0000007F.
  - Response: states 0,1,0; illegal=1 only in state 1; no reg_write or mem_write.
- Fetch stall and mid-run reset:
  - Fetch with mem_ready=0 for 4 cycles → ir_write=0 and pc_write=0 until mem_ready=1, then both 1 for one cycle.
  - rst_n=0 during state 6 → next state 0 and reg_write never asserted.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_main_control_if
// Brief   : Instruction/handshake inputs and datapath controls of the
//           multicycle main control unit.
// Revision: 1.0 - initial release
// ============================================================================
interface multicycle_main_control_if;
    logic [31:0] instruction;
    logic        mem_ready;
    logic [1:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_source;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic [3:0]  state;

    // master is the controller; slave is the datapath/memory side
    modport master (
        input  instruction, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond,
               pc_source, iord, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, illegal, state
    );

    modport slave (
        output instruction, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond,
               pc_source, iord, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_main_control
// Brief   : Moore-style main control FSM for the multicycle RV32I subset
//           (R-type, LW, SW, BEQ) with memory-ready gating.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_main_control (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    multicycle_main_control_if.master  bus
);

    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [6:0]  w_opcode;
    logic [1:0]  w_alu_op;
    logic        w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic        w_pc_write;
    logic        w_pc_write_cond;
    logic        w_pc_source;
    logic        w_iord;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_illegal;
    logic        w_unused_instr_bits;

    assign w_opcode            = bus.instruction[6:0];
    assign w_unused_instr_bits = ^bus.instruction[31:7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = S_FETCH;
        w_alu_op        = 2'b00;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_source     = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                // IR/PC load are the only terms gated directly by mem_ready
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b10;
                case (w_opcode)
                    c_OP_LW, c_OP_SW: state_d = S_MEM_ADDR;
                    c_OP_RTYPE:       state_d = S_EXECUTE;
                    c_OP_BEQ:         state_d = S_BRANCH;
                    default: begin
                        w_illegal = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                case (w_opcode)
                    c_OP_LW: state_d = S_MEM_READ;
                    c_OP_SW: state_d = S_MEM_WRITE;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                state_d    = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                state_d     = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 1'b1;
                state_d         = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset masks every output so no strobe escapes while rst_n is low
    assign bus.alu_op        = rst_n ? w_alu_op        : 2'b00;
    assign bus.alu_src_a     = rst_n ? w_alu_src_a     : 1'b0;
    assign bus.alu_src_b     = rst_n ? w_alu_src_b     : 2'b00;
    assign bus.pc_write      = rst_n ? w_pc_write      : 1'b0;
    assign bus.pc_write_cond = rst_n ? w_pc_write_cond : 1'b0;
    assign bus.pc_source     = rst_n ? w_pc_source     : 1'b0;
    assign bus.iord          = rst_n ? w_iord          : 1'b0;
    assign bus.mem_read      = rst_n ? w_mem_read      : 1'b0;
    assign bus.mem_write     = rst_n ? w_mem_write     : 1'b0;
    assign bus.ir_write      = rst_n ? w_ir_write      : 1'b0;
    assign bus.reg_write     = rst_n ? w_reg_write     : 1'b0;
    assign bus.mem_to_reg    = rst_n ? w_mem_to_reg    : 1'b0;
    assign bus.illegal       = rst_n ? w_illegal       : 1'b0;
    assign bus.state         = rst_n ? state_q         : 4'd0;

endmodule
`default_nettype wire
